// File: rtl/fp_int_mac_seq_pkg.sv
// ---------------------------------------------------------------------------
// fp_int_mac_seq_pkg
// Shared definitions for the FP16 x INT bit-serial MAC sequencer:
//   - sequencer state encoding
//   - default widths (activation, max weight precision, vector length)
//   - precision legality check used when a vector is configured
// ---------------------------------------------------------------------------
package fp_int_mac_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int DEF_ACT_WIDTH = 16;
   localparam int DEF_MAX_PREC  = 8;
   localparam int DEF_LEN_W     = 10;

   // A precision is usable when it selects at least one bit and no more
   // bits than the weight port carries.
   function automatic logic prec_legal(input logic [3:0] prec, input int max_prec);
      return (prec != 4'd0) && (int'(prec) <= max_prec);
   endfunction

endpackage

// File: rtl/fp_int_mac_seq_wbit_serializer.sv
// ---------------------------------------------------------------------------
// fp_int_mac_seq_wbit_serializer
// One-entry operand register that holds an activation and shifts its weight
// out one bit per cycle, MSB (sign) first.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_load        load a new operand (activation + weight) this cycle
//   i_act         activation to hold for the serial group
//   i_w           weight, right-aligned two's complement in i_prec bits
//   i_prec        weight precision (stable for the whole vector)
//   o_op_v        operand register holds a valid operand (bit is valid)
//   o_bit         current serial weight bit
//   o_last        current bit is the last one of the group
//   o_act         held activation
// ---------------------------------------------------------------------------
module fp_int_mac_seq_wbit_serializer #(
   parameter int ACT_WIDTH = 16,
   parameter int MAX_PREC  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic [ACT_WIDTH-1:0] i_act,
   input  logic [MAX_PREC-1:0]  i_w,
   input  logic [3:0]           i_prec,
   output logic                 o_op_v,
   output logic                 o_bit,
   output logic                 o_last,
   output logic [ACT_WIDTH-1:0] o_act
);

   localparam logic [3:0] MP = 4'(MAX_PREC);

   logic [MAX_PREC-1:0]  r_sh;
   logic [3:0]           r_bit_cnt;
   logic                 r_op_v;
   logic [ACT_WIDTH-1:0] r_act;

   logic [3:0]           w_shamt;
   logic [MAX_PREC-1:0]  w_aligned;
   logic                 w_last;

   // Left-justify the weight so bit prec-1 sits in the MSB; any sign
   // extension above the precision falls off the top.
   assign w_shamt   = MP - i_prec;
   assign w_aligned = i_w << w_shamt;
   assign w_last    = r_op_v && (r_bit_cnt == (i_prec - 4'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sh      <= '0;
         r_bit_cnt <= '0;
         r_op_v    <= 1'b0;
         r_act     <= '0;
      end else if (i_load) begin
         r_sh      <= w_aligned;
         r_bit_cnt <= '0;
         r_op_v    <= 1'b1;
         r_act     <= i_act;
      end else if (r_op_v) begin
         // Zeros shift in behind the weight, so the bit output idles at 0.
         r_sh <= r_sh << 1;
         if (w_last) begin
            r_op_v    <= 1'b0;
            r_bit_cnt <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
      end
   end

   assign o_op_v = r_op_v;
   assign o_bit  = r_sh[MAX_PREC-1];
   assign o_last = w_last;
   assign o_act  = r_act;

endmodule

// File: rtl/fp_int_mac_seq.sv
// ---------------------------------------------------------------------------
// fp_int_mac_seq
// Sequencer feeding the bit-serial fp_int_mul datapath. Accepts
// (FP16 activation, INT weight) pairs, streams each weight MSB first while
// holding the activation, counts returned products and flags completion.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cfg_valid           start-vector strobe (sampled only when idle)
//   cfg_precision       weight bits per operand, 1..MAX_PREC
//   cfg_len             operand pairs in the vector
//   cfg_err             pulse on a start strobe with illegal precision
//   in_valid/in_ready   operand handshake
//   in_act, in_w        activation and right-aligned weight
//   mul_act/mul_w/mul_valid/mul_precision   serial stream to fp_int_mul
//   mul_start_acc       product-ready pulse from fp_int_mul
//   acc_clear           pulse at vector start
//   busy                high while a vector is in progress
//   done                pulse when all products have returned
// ---------------------------------------------------------------------------
module fp_int_mac_seq
   import fp_int_mac_seq_pkg::*;
#(
   parameter int ACT_WIDTH = DEF_ACT_WIDTH,
   parameter int MAX_PREC  = DEF_MAX_PREC,
   parameter int LEN_W     = DEF_LEN_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   input  logic [3:0]           cfg_precision,
   input  logic [LEN_W-1:0]     cfg_len,
   output logic                 cfg_err,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ACT_WIDTH-1:0] in_act,
   input  logic [MAX_PREC-1:0]  in_w,
   output logic [ACT_WIDTH-1:0] mul_act,
   output logic                 mul_w,
   output logic                 mul_valid,
   output logic [3:0]           mul_precision,
   input  logic                 mul_start_acc,
   output logic                 acc_clear,
   output logic                 busy,
   output logic                 done
);

   state_t           r_state;
   logic [3:0]       r_prec;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_accepted;
   logic [LEN_W-1:0] r_returned;
   logic             r_acc_clear;
   logic             r_done;
   logic             r_cfg_err;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_op_v;
   logic             w_last;
   logic             w_ret_inc;

   // A new operand may load while the current one emits its last bit,
   // which keeps the serial stream free of bubbles.
   assign w_in_ready = (r_state == ST_RUN) && (r_accepted < r_len) &&
                       (!w_op_v || w_last);
   assign w_accept   = in_valid && w_in_ready;
   // Surplus product pulses beyond the vector length are dropped.
   assign w_ret_inc  = mul_start_acc && (r_returned < r_len);

   fp_int_mac_seq_wbit_serializer #(
      .ACT_WIDTH (ACT_WIDTH),
      .MAX_PREC  (MAX_PREC)
   ) u_ser (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept),
      .i_act  (in_act),
      .i_w    (in_w),
      .i_prec (r_prec),
      .o_op_v (w_op_v),
      .o_bit  (mul_w),
      .o_last (w_last),
      .o_act  (mul_act)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_prec      <= '0;
         r_len       <= '0;
         r_accepted  <= '0;
         r_returned  <= '0;
         r_acc_clear <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_acc_clear <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  if (prec_legal(cfg_precision, MAX_PREC)) begin
                     r_prec     <= cfg_precision;
                     r_len      <= cfg_len;
                     r_accepted <= '0;
                     r_returned <= '0;
                     // An empty vector completes at once without clearing
                     // the accumulator.
                     if (cfg_len == '0) begin
                        r_done <= 1'b1;
                     end else begin
                        r_acc_clear <= 1'b1;
                        r_state     <= ST_RUN;
                     end
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_accept)  r_accepted <= r_accepted + LEN_W'(1);
               if (w_ret_inc) r_returned <= r_returned + LEN_W'(1);
               if ((r_accepted == r_len) && (!w_op_v || w_last))
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_ret_inc) r_returned <= r_returned + LEN_W'(1);
               if (r_returned == r_len) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready      = w_in_ready;
   assign mul_valid     = w_op_v;
   assign mul_precision = r_prec;
   assign acc_clear     = r_acc_clear;
   assign busy          = (r_state != ST_IDLE);
   assign done          = r_done;
   assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_fp_int_mac_seq.sv
module tb_fp_int_mac_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic [3:0]  cfg_precision;
   logic [9:0]  cfg_len;
   logic        cfg_err;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_act;
   logic [7:0]  in_w;
   logic [15:0] mul_act;
   logic        mul_w;
   logic        mul_valid;
   logic [3:0]  mul_precision;
   logic        mul_start_acc;
   logic        acc_clear;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fp_int_mac_seq dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_valid     (cfg_valid),
      .cfg_precision (cfg_precision),
      .cfg_len       (cfg_len),
      .cfg_err       (cfg_err),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_act        (in_act),
      .in_w          (in_w),
      .mul_act       (mul_act),
      .mul_w         (mul_w),
      .mul_valid     (mul_valid),
      .mul_precision (mul_precision),
      .mul_start_acc (mul_start_acc),
      .acc_clear     (acc_clear),
      .busy          (busy),
      .done          (done)
   );

   // single-operand vectors: exp holds the prec bits in emission order (MSB first)
   typedef struct {
      logic [3:0]  prec;
      logic [15:0] act;
      logic [7:0]  w;
      logic [7:0]  exp;
   } vec_t;

   // per-cycle expectations for streaming sequences
   typedef struct {
      logic        iv;
      logic        ir;
      logic        mv;
      logic        mw;
      logic [15:0] act;
   } cyc_t;

   vec_t        vt [5];
   cyc_t        tab [16];
   logic [15:0] op_act [3];
   logic [7:0]  op_w [3];

   function automatic cyc_t mk(logic iv, logic ir, logic mv, logic mw, logic [15:0] a);
      cyc_t c;
      c.iv = iv; c.ir = ir; c.mv = mv; c.mw = mw; c.act = a;
      return c;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_done(input string nm, input int win);
      int n;
      n = 0;
      repeat (win) begin
         @(negedge clk);
         if (done) n++;
      end
      chk({nm, " done pulses"}, n, 1);
      chk({nm, " busy after"}, busy, 0);
   endtask

   task automatic run_single(input int idx);
      vec_t v;
      v = vt[idx];
      tick;
      cfg_valid = 1'b1; cfg_precision = v.prec; cfg_len = 10'd1;
      tick;
      cfg_valid = 1'b0; in_valid = 1'b1; in_act = v.act; in_w = v.w;
      @(negedge clk);
      chk($sformatf("v%0d acc_clear", idx), acc_clear, 1);
      chk($sformatf("v%0d busy", idx), busy, 1);
      chk($sformatf("v%0d in_ready", idx), in_ready, 1);
      chk($sformatf("v%0d mul_precision", idx), mul_precision, v.prec);
      tick;
      in_valid = 1'b0;
      for (int j = 0; j < int'(v.prec); j++) begin
         @(negedge clk);
         chk($sformatf("v%0d b%0d mul_valid", idx, j), mul_valid, 1);
         chk($sformatf("v%0d b%0d mul_w", idx, j), mul_w, v.exp[int'(v.prec) - 1 - j]);
         chk($sformatf("v%0d b%0d mul_act", idx, j), mul_act, v.act);
         if (j == 0) chk($sformatf("v%0d in_ready busy", idx), in_ready, 0);
         tick;
      end
      @(negedge clk);
      chk($sformatf("v%0d mul_valid end", idx), mul_valid, 0);
      chk($sformatf("v%0d busy drain", idx), busy, 1);
      chk($sformatf("v%0d no early done", idx), done, 0);
      tick;
      mul_start_acc = 1'b1;
      tick;
      mul_start_acc = 1'b0;
      chk_done($sformatf("v%0d", idx), 4);
   endtask

   task automatic run_cycles(input string nm, input int n, input logic [3:0] prec, input logic [9:0] len);
      int   k;
      logic acc;
      k = 0;
      tick;
      cfg_valid = 1'b1; cfg_precision = prec; cfg_len = len;
      tick;
      cfg_valid = 1'b0;
      for (int c = 0; c < n; c++) begin
         in_valid = tab[c].iv; in_act = op_act[k]; in_w = op_w[k];
         @(negedge clk);
         chk($sformatf("%s c%0d in_ready", nm, c), in_ready, tab[c].ir);
         chk($sformatf("%s c%0d mul_valid", nm, c), mul_valid, tab[c].mv);
         if (tab[c].mv) begin
            chk($sformatf("%s c%0d mul_w", nm, c), mul_w, tab[c].mw);
            chk($sformatf("%s c%0d mul_act", nm, c), mul_act, tab[c].act);
         end
         acc = in_valid && in_ready;
         tick;
         if (acc && k < 2) k++;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_done;
      int n_done;

      vt[0] = '{prec: 4'd4, act: 16'h1234, w: 8'h05, exp: 8'b0000_0101};
      vt[1] = '{prec: 4'd3, act: 16'h3C00, w: 8'hFD, exp: 8'b0000_0101};
      vt[2] = '{prec: 4'd8, act: 16'hABCD, w: 8'h96, exp: 8'b1001_0110};
      vt[3] = '{prec: 4'd1, act: 16'h7BFF, w: 8'hFF, exp: 8'b0000_0001};
      vt[4] = '{prec: 4'd5, act: 16'hC000, w: 8'hEB, exp: 8'b0000_1011};

      rst = 1'b0; cfg_valid = 1'b0; cfg_precision = 4'd0; cfg_len = 10'd0;
      in_valid = 1'b0; in_act = 16'h0; in_w = 8'h0; mul_start_acc = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst mul_valid", mul_valid, 0);
      chk("rst mul_w", mul_w, 0);
      chk("rst mul_act", mul_act, 0);
      chk("rst mul_precision", mul_precision, 0);
      chk("rst in_ready", in_ready, 0);
      chk("rst acc_clear", acc_clear, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst cfg_err", cfg_err, 0);
      rst = 1'b1;

      // single-operand vectors, including sign-extended weights
      for (int i = 0; i < 5; i++) run_single(i);

      // back-to-back streaming, prec=4 len=3
      op_act[0] = 16'hAAAA; op_w[0] = 8'h0C;
      op_act[1] = 16'h5555; op_w[1] = 8'h03;
      op_act[2] = 16'h0F0F; op_w[2] = 8'h0A;
      tab[0]  = mk(1, 1, 0, 0, 16'h0);
      tab[1]  = mk(1, 0, 1, 1, 16'hAAAA);
      tab[2]  = mk(1, 0, 1, 1, 16'hAAAA);
      tab[3]  = mk(1, 0, 1, 0, 16'hAAAA);
      tab[4]  = mk(1, 1, 1, 0, 16'hAAAA);
      tab[5]  = mk(1, 0, 1, 0, 16'h5555);
      tab[6]  = mk(1, 0, 1, 0, 16'h5555);
      tab[7]  = mk(1, 0, 1, 1, 16'h5555);
      tab[8]  = mk(1, 1, 1, 1, 16'h5555);
      tab[9]  = mk(1, 0, 1, 1, 16'h0F0F);
      tab[10] = mk(1, 0, 1, 0, 16'h0F0F);
      tab[11] = mk(1, 0, 1, 1, 16'h0F0F);
      tab[12] = mk(1, 0, 1, 0, 16'h0F0F);
      tab[13] = mk(1, 0, 0, 0, 16'h0);
      run_cycles("stream", 14, 4'd4, 10'd3);
      mul_start_acc = 1'b1;
      repeat (3) tick;
      mul_start_acc = 1'b0;
      chk_done("stream", 4);

      // illegal configs and empty vector
      tick; cfg_valid = 1'b1; cfg_precision = 4'd0; cfg_len = 10'd2;
      tick; cfg_valid = 1'b0;
      @(negedge clk);
      chk("prec0 cfg_err", cfg_err, 1);
      chk("prec0 busy", busy, 0);
      tick;
      @(negedge clk);
      chk("prec0 cfg_err clear", cfg_err, 0);
      tick; cfg_valid = 1'b1; cfg_precision = 4'd9; cfg_len = 10'd2;
      tick; cfg_valid = 1'b0;
      @(negedge clk);
      chk("prec9 cfg_err", cfg_err, 1);
      chk("prec9 busy", busy, 0);
      tick; cfg_valid = 1'b1; cfg_precision = 4'd2; cfg_len = 10'd0;
      tick; cfg_valid = 1'b0;
      @(negedge clk);
      chk("len0 done", done, 1);
      chk("len0 acc_clear", acc_clear, 0);
      chk("len0 busy", busy, 0);
      chk("len0 cfg_err", cfg_err, 0);
      tick;
      @(negedge clk);
      chk("len0 done clear", done, 0);

      // input stall, prec=2 len=2
      op_act[0] = 16'h1111; op_w[0] = 8'h01;
      op_act[1] = 16'h2222; op_w[1] = 8'h02;
      op_act[2] = 16'h0000; op_w[2] = 8'h00;
      tab[0] = mk(1, 1, 0, 0, 16'h0);
      tab[1] = mk(0, 0, 1, 0, 16'h1111);
      tab[2] = mk(0, 1, 1, 1, 16'h1111);
      tab[3] = mk(0, 1, 0, 0, 16'h0);
      tab[4] = mk(1, 1, 0, 0, 16'h0);
      tab[5] = mk(0, 0, 1, 1, 16'h2222);
      tab[6] = mk(0, 0, 1, 0, 16'h2222);
      tab[7] = mk(0, 0, 0, 0, 16'h0);
      run_cycles("stall", 8, 4'd2, 10'd2);
      mul_start_acc = 1'b1;
      repeat (2) tick;
      mul_start_acc = 1'b0;
      chk_done("stall", 4);

      // drain ordering: last bit at c4, products at c9 and c13
      tab[0] = mk(1, 1, 0, 0, 16'h0);
      tab[1] = mk(1, 0, 1, 0, 16'h1111);
      tab[2] = mk(1, 1, 1, 1, 16'h1111);
      tab[3] = mk(1, 0, 1, 1, 16'h2222);
      tab[4] = mk(1, 0, 1, 0, 16'h2222);
      tab[5] = mk(1, 0, 0, 0, 16'h0);
      run_cycles("drain", 6, 4'd2, 10'd2);
      first_done = -1;
      n_done = 0;
      for (int cyc = 6; cyc <= 20; cyc++) begin
         mul_start_acc = (cyc == 9) || (cyc == 13);
         @(negedge clk);
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = cyc;
         end
         tick;
      end
      mul_start_acc = 1'b0;
      chk("drain first done cycle", first_done, 15);
      chk("drain done pulses", n_done, 1);
      chk("drain busy after", busy, 0);
      // stray product pulse while idle, then a normal vector
      mul_start_acc = 1'b1;
      tick;
      mul_start_acc = 1'b0;
      run_single(0);

      // asynchronous reset mid-RUN, on the second bit of a prec=4 operand
      tick; cfg_valid = 1'b1; cfg_precision = 4'd4; cfg_len = 10'd2;
      tick; cfg_valid = 1'b0; in_valid = 1'b1; in_act = 16'h1234; in_w = 8'h05;
      tick; in_valid = 1'b0;
      tick;
      @(negedge clk);
      chk("midrst pre mul_valid", mul_valid, 1);
      chk("midrst pre busy", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst mul_valid", mul_valid, 0);
      chk("midrst in_ready", in_ready, 0);
      chk("midrst busy", busy, 0);
      chk("midrst mul_act", mul_act, 0);
      chk("midrst mul_precision", mul_precision, 0);
      @(negedge clk);
      rst = 1'b1;
      run_single(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
